// File: rtl/aes128_encrypt_iter_pkg.sv
// Shared AES-128 constants, types and byte-level helpers for the encrypt core.
// Byte i of a 128-bit block sits at bits [8i:8i+7], column-major (row=i%4, col=i/4).
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int NR      = 10;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam byte_t RCON [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Source byte for ShiftRows output byte i: row r moves left by r columns.
    function automatic logic [3:0] sr_idx(input logic [3:0] i);
        return i + {i[1:0], 2'b00};
    endfunction

endpackage

// File: rtl/aes128_encrypt_iter_if.sv
// Request/response bundle between a block source and the iterative AES encrypt core.
// The source drives start with key and plaintext; the core returns busy, done and ciphertext.
interface aes128_encrypt_iter_if;
    import aes_pkg::*;

    logic               start;
    logic [0:BLOCK_W-1] keyIn;
    logic [0:BLOCK_W-1] stateIn;
    logic               busy;
    logic               done;
    logic [0:BLOCK_W-1] stateOut;

    modport master (output start, keyIn, stateIn, input busy, done, stateOut);
    modport slave  (input start, keyIn, stateIn, output busy, done, stateOut);

endinterface

// File: rtl/aes128_encrypt_iter_sbox.sv
// Forward AES S-box, purely combinational: GF(2^8) inverse (b^254) then the affine map.
// Zero latency, no handshake.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t in_b,
    output byte_t out_b
);

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic byte_t rotl(input byte_t b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    byte_t p2, p4, p8, p16, p32, p64, p128, inv;

    assign p2   = gf_mul(in_b, in_b);
    assign p4   = gf_mul(p2, p2);
    assign p8   = gf_mul(p4, p4);
    assign p16  = gf_mul(p8, p8);
    assign p32  = gf_mul(p16, p16);
    assign p64  = gf_mul(p32, p32);
    assign p128 = gf_mul(p64, p64);
    // 254 = 2+4+8+16+32+64+128, so this is the multiplicative inverse (0 maps to 0).
    assign inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                         gf_mul(gf_mul(p32, p64), p128));

    assign out_b = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption, one round per clock with on-the-fly key expansion.
// Ciphertext and done appear 11 cycles after start; start is ignored while busy.
module aes128_encrypt_iter
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    aes128_encrypt_iter_if.slave bus
);

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [3:0]         round_q, round_d;
    logic [0:BLOCK_W-1] state_q, state_d;
    logic [0:BLOCK_W-1] key_q, key_d;
    logic [0:BLOCK_W-1] out_q, out_d;
    logic               done_q, done_d;

    byte_t              sb_out [16];
    byte_t              sr     [16];
    byte_t              mc     [16];
    byte_t              sw_out [4];
    word_t              w0, w1, w2, w3, rot_w, sub_w, nk0, nk1, nk2, nk3;
    logic [3:0]         rcon_idx;
    logic [0:BLOCK_W-1] next_key;
    logic [0:BLOCK_W-1] round_out;

    genvar gi;
    for (gi = 0; gi < 16; gi++) begin : g_state_sbox
        aes_sbox u_sbox (.in_b(state_q[8*gi +: 8]), .out_b(sb_out[gi]));
    end
    for (gi = 0; gi < 4; gi++) begin : g_key_sbox
        aes_sbox u_sbox (.in_b(rot_w[31-8*gi -: 8]), .out_b(sw_out[gi]));
    end

    assign w0       = key_q[0  +: 32];
    assign w1       = key_q[32 +: 32];
    assign w2       = key_q[64 +: 32];
    assign w3       = key_q[96 +: 32];
    assign rot_w    = {w3[23:0], w3[31:24]};
    assign sub_w    = {sw_out[0], sw_out[1], sw_out[2], sw_out[3]};
    assign rcon_idx = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
    assign nk0      = w0 ^ sub_w ^ {RCON[rcon_idx], 24'h000000};
    assign nk1      = w1 ^ nk0;
    assign nk2      = w2 ^ nk1;
    assign nk3      = w3 ^ nk2;
    assign next_key = {nk0, nk1, nk2, nk3};

    always_comb begin
        round_out = '0;
        for (int b = 0; b < 16; b++) begin
            sr[b] = sb_out[sr_idx(4'(b))];
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        // The final round has no MixColumns.
        for (int b = 0; b < 16; b++) begin
            round_out[8*b +: 8] = ((round_q == LAST_ROUND) ? sr[b] : mc[b]) ^ next_key[8*b +: 8];
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        key_d   = key_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (bus.start) begin
                    fsm_d   = RUN;
                    state_d = bus.stateIn ^ bus.keyIn;
                    key_d   = bus.keyIn;
                    round_d = 4'd1;
                end
            end
            RUN: begin
                state_d = round_out;
                key_d   = next_key;
                if (round_q == LAST_ROUND) begin
                    fsm_d   = IDLE;
                    out_d   = round_out;
                    done_d  = 1'b1;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            state_q <= '0;
            key_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            key_q   <= key_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = (fsm_q == RUN);
    assign bus.done     = done_q;
    assign bus.stateOut = out_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Directed FIPS-197 vectors plus control-path scenarios for the iterative AES-128 encryptor.
module tb_aes128_encrypt_iter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    aes128_encrypt_iter_if bus ();

    aes128_encrypt_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [0:127] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    // Drives one start pulse and waits (bounded) for done; lat=-1 on timeout.
    task automatic run_block(input logic [0:127] k, input logic [0:127] p,
                             output int lat, output logic [0:127] ct);
        lat = -1;
        ct  = '0;
        bus.keyIn   = k;
        bus.stateIn = p;
        bus.start   = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                bus.start   = 1'b0;
                bus.keyIn   = '1;
                bus.stateIn = '1;
            end
            if (bus.done) begin
                lat = c;
                ct  = bus.stateOut;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.keyIn = '0;
        bus.stateIn = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if (bus.stateOut !== 128'h0) begin n_fail++; $display("FAIL reset_out got %h want 0", bus.stateOut); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fips_b();
        int lat;
        logic [0:127] ct;
        run_block(KEY_B, PT_B, lat, ct);
        n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL fips_b_latency got %0d want 11", lat); end
        n_cmp++; if (ct !== CT_B) begin n_fail++; $display("FAIL fips_b_ct got %h want %h", ct, CT_B); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fips_b_busy_at_done got %b want 0", bus.busy); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL fips_b_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic test_fips_c1();
        int lat;
        logic [0:127] ct;
        run_block(KEY_C1, PT_C1, lat, ct);
        n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL fips_c1_latency got %0d want 11", lat); end
        n_cmp++; if (ct !== CT_C1) begin n_fail++; $display("FAIL fips_c1_ct got %h want %h", ct, CT_C1); end
    endtask

    task automatic test_zero_hold();
        int lat;
        logic [0:127] ct;
        int bad_out;
        int bad_done;
        run_block(128'h0, 128'h0, lat, ct);
        n_cmp++; if (ct !== CT_Z) begin n_fail++; $display("FAIL zero_ct got %h want %h", ct, CT_Z); end
        bad_out = 0;
        bad_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.stateOut !== CT_Z) bad_out++;
            if (bus.done !== 1'b0) bad_done++;
        end
        n_cmp++; if (bad_out !== 0) begin n_fail++; $display("FAIL zero_hold_out cycles_changed %0d want 0", bad_out); end
        n_cmp++; if (bad_done !== 0) begin n_fail++; $display("FAIL zero_hold_done extra_done %0d want 0", bad_done); end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int first;
        logic [0:127] ct;
        ndone = 0;
        first = -1;
        ct = '0;
        bus.keyIn = KEY_B;
        bus.stateIn = PT_B;
        bus.start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                ndone++;
                if (first < 0) begin first = c; ct = bus.stateOut; end
            end
            bus.start = (c == 3 || c == 7);
            bus.keyIn = KEY_C1;
            bus.stateIn = PT_C1;
        end
        bus.start = 1'b0;
        n_cmp++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
        n_cmp++; if (first !== 11) begin n_fail++; $display("FAIL ignore_latency got %0d want 11", first); end
        n_cmp++; if (ct !== CT_B) begin n_fail++; $display("FAIL ignore_ct got %h want %h", ct, CT_B); end
    endtask

    task automatic test_back_to_back();
        int first;
        int second;
        logic busy_after;
        logic [0:127] ct1;
        logic [0:127] ct2;
        first = -1;
        second = -1;
        busy_after = 1'b0;
        ct1 = '0;
        ct2 = '0;
        bus.keyIn = KEY_B;
        bus.stateIn = PT_B;
        bus.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                if (first < 0) begin
                    first = c;
                    ct1 = bus.stateOut;
                    bus.keyIn = KEY_C1;
                    bus.stateIn = PT_C1;
                end else begin
                    second = c;
                    ct2 = bus.stateOut;
                    break;
                end
            end else if (first >= 0 && c == first + 1) begin
                busy_after = bus.busy;
                bus.start = 1'b0;
                bus.keyIn = '0;
                bus.stateIn = '0;
            end
        end
        bus.start = 1'b0;
        n_cmp++; if (first !== 11) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 11", first); end
        n_cmp++; if (ct1 !== CT_B) begin n_fail++; $display("FAIL b2b_ct1 got %h want %h", ct1, CT_B); end
        n_cmp++; if (busy_after !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept busy %b want 1", busy_after); end
        n_cmp++; if (second - first !== 11) begin n_fail++; $display("FAIL b2b_spacing got %0d want 11", second - first); end
        n_cmp++; if (ct2 !== CT_C1) begin n_fail++; $display("FAIL b2b_ct2 got %h want %h", ct2, CT_C1); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int ndone;
        logic [0:127] ct;
        bus.keyIn = KEY_B;
        bus.stateIn = PT_B;
        bus.start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", bus.done); end
        n_cmp++; if (bus.stateOut !== 128'h0) begin n_fail++; $display("FAIL midrst_out got %h want 0", bus.stateOut); end
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        n_cmp++; if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
        run_block(KEY_C1, PT_C1, lat, ct);
        n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL midrst_rerun_latency got %0d want 11", lat); end
        n_cmp++; if (ct !== CT_C1) begin n_fail++; $display("FAIL midrst_rerun_ct got %h want %h", ct, CT_C1); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.keyIn = '0;
        bus.stateIn = '0;
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_zero_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
